y86_prefetch_buffer: RTL

- Instruction prefetch stage directly upstream of the Y86-64 fetch stage.
- Fetches aligned 64-bit words from instruction memory through a req/gnt/rvalid handshake and holds them in a circular byte queue.
- Length-decodes the head instruction from its icode and presents up to 10 little-endian bytes with PC, length and error status to fetch via a valid/ready handshake.
- Flushes and refetches on a PC redirect (jump, call, ret, mispredict).

---
 rtl/y86_prefetch_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/y86_prefetch_buffer.sv
// Y86-64 instruction prefetch buffer: fetches aligned 64-bit words into a
// circular byte queue and presents the length-decoded head instruction to fetch.
module y86_prefetch_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] out_bytes,
  output logic [63:0] out_pc,
  output logic [3:0]  out_len,
  output logic        out_imem_error,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rerror
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned OUT_BYTES  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_q [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [63:0]   r_head_pc;
  logic [63:0]   r_fetch_addr;
  logic [2:0]    r_skip;
  logic          r_drop;
  logic          r_err;
  logic          r_mem_req;
  logic [63:0]   r_mem_addr;

  logic [3:0]    w_len;
  logic          w_has_instr;
  logic          w_err_state;
  logic          w_consume;
  logic          w_resp;
  logic          w_wr;
  logic          w_space_ok;
  logic [CW-1:0] w_written;
  logic [CW-1:0] w_consumed;

  // Length decode from the head icode; unknown icodes are passed through as 1 byte
  always_comb begin
    w_len = 4'd1;
    case (r_q[r_head][7:4])
      4'h0, 4'h1, 4'h9:       w_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
      4'h3, 4'h4, 4'h5:       w_len = 4'd10;
      4'h7, 4'h8:             w_len = 4'd9;
      default:                w_len = 4'd1;
    endcase
  end

  // A complete head instruction is delivered even after a later word faulted
  assign w_has_instr = (r_count >= CW'(w_len));
  assign w_err_state = r_err && !w_has_instr;
  assign w_consume   = w_has_instr && out_ready && !redirect_valid;
  assign w_consumed  = w_consume ? CW'(w_len) : '0;

  assign w_resp     = (r_state == ST_WAIT) && mem_rvalid;
  assign w_wr       = w_resp && !r_drop && !mem_rerror && !redirect_valid;
  assign w_written  = w_wr ? CW'(4'd8 - {1'b0, r_skip}) : '0;
  assign w_space_ok = (CW'(DEPTH) - r_count) >= CW'(WORD_BYTES);

  assign out_valid      = w_has_instr || r_err;
  assign out_imem_error = w_err_state;
  assign out_len        = w_err_state ? 4'd0 : w_len;
  assign out_pc         = r_head_pc;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;

  // Gather the head bytes, wrapping around the end of the queue
  always_comb begin
    out_bytes = '0;
    for (int i = 0; i < int'(OUT_BYTES); i++) begin
      out_bytes[8*i +: 8] = r_q[r_head + AW'(i)];
    end
  end

  // Response payload: bytes below the entry skip offset are not part of the stream
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int j = 0; j < int'(WORD_BYTES); j++) begin
        if (3'(j) >= r_skip) begin
          r_q[r_tail + AW'(j) - AW'(r_skip)] <= mem_rdata[8*j +: 8];
        end
      end
    end
  end

  // Queue pointers, PC tracking and the single-outstanding memory FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_head_pc    <= RESET_PC;
      r_fetch_addr <= {RESET_PC[63:3], 3'b000};
      r_skip       <= RESET_PC[2:0];
      r_drop       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else if (redirect_valid) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
      r_head_pc    <= redirect_pc;
      r_fetch_addr <= {redirect_pc[63:3], 3'b000};
      r_skip       <= redirect_pc[2:0];
      r_mem_req    <= 1'b0;
      case (r_state)
        ST_REQ: begin
          // A granted request still owes a response that must be discarded
          if (mem_gnt) begin
            r_state <= ST_WAIT;
            r_drop  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      r_count <= r_count - w_consumed + w_written;
      if (w_consume) begin
        r_head    <= r_head + AW'(w_len);
        r_head_pc <= r_head_pc + 64'(w_len);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_space_ok && !r_err && !r_drop) begin
            r_state    <= ST_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_addr;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_state      <= ST_WAIT;
            r_mem_req    <= 1'b0;
            r_fetch_addr <= r_fetch_addr + 64'd8;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state <= ST_IDLE;
            if (r_drop) begin
              r_drop <= 1'b0;
            end else if (mem_rerror) begin
              r_err <= 1'b1;
            end else begin
              r_tail <= r_tail + AW'(w_written);
              r_skip <= 3'd0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
